// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencer streaming A/B operand reads, MAC and C writes for an NxN matmul
// Ports: clk/rstn (sync active-low), start -> busy/done handshake,
//        addr_a/addr_b/nce_ab read port to MEM A/B with dout_a/dout_b one cycle later,
//        addr_c/din_c/nwrt_c/nce_c write port to MEM C.
module matmul_seq_ctrl #(
    parameter int N_LOG2 = 6,
    parameter int DW     = 8,
    parameter int ACC_W  = 2*DW+N_LOG2,
    parameter int AW     = 2*N_LOG2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    addr_a,
    output logic [AW-1:0]    addr_b,
    output logic             nce_ab,
    input  logic [DW-1:0]    dout_a,
    input  logic [DW-1:0]    dout_b,
    output logic [AW-1:0]    addr_c,
    output logic [ACC_W-1:0] din_c,
    output logic             nwrt_c,
    output logic             nce_c
);
    localparam int NW = 3*N_LOG2;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;
    logic [NW-1:0] n;
    logic [N_LOG2-1:0] i, j, k, k1;
    logic [AW-1:0] ij1;
    logic [2*DW-1:0] p;
    logic [ACC_W-1:0] acc;
    logic fl, v1;
    assign {i, j, k} = n;
    assign addr_a = {i, k};
    assign addr_b = {k, j};
    assign p = dout_a * dout_b;
    assign din_c = acc;
    assign nce_c = nwrt_c;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = start ? RUN : IDLE;
            RUN:   state_nx = &n ? FLUSH : RUN;
            FLUSH: state_nx = fl ? DONE : FLUSH;
            DONE:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            n      <= '0;
            fl     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            nce_ab <= 1'b1;
            v1     <= 1'b0;
            k1     <= '0;
            ij1    <= '0;
            acc    <= '0;
            nwrt_c <= 1'b1;
            addr_c <= '0;
        end else begin
            state  <= state_nx;
            n      <= (state == RUN) ? n + 1'b1 : '0;
            fl     <= (state == FLUSH) ? ~fl : 1'b0;
            busy   <= state_nx != IDLE;
            done   <= state_nx == DONE;
            nce_ab <= state_nx != RUN;
            // stage 1: k and {i,j} travel alongside the read data
            v1     <= state == RUN;
            k1     <= k;
            ij1    <= {i, j};
            if (v1)
                acc <= (k1 == '0) ? ACC_W'(p) : acc + ACC_W'(p);
            // stage 2: the write sees the finished sum while acc reloads for the next element
            nwrt_c <= !(v1 && &k1);
            if (v1 && &k1)
                addr_c <= ij1;
        end
    end
endmodule
